// File: rtl/element_delay_accumulator_pkg.sv
// Shared types and helpers for the element delay accumulator.
// It holds the fixed-point width defaults, the term type, the control state encoding
// and a saturating add at the default width.
package delay_pkg;

  localparam int DEF_DW_INTEGER  = 18;
  localparam int DEF_DW_FRACTION = 6;
  localparam int DEF_W           = DEF_DW_INTEGER + DEF_DW_FRACTION + 1;

  // Signed fixed-point delay/term: sign + integer + fraction bits
  typedef logic signed [DEF_W-1:0] fixed_term_t;

  // Control sequence for one scan line
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ACK   = 3'd3,
    ST_EMIT  = 3'd4,
    ST_DONE  = 3'd5
  } acc_state_e;

  // Add two terms. The sum is computed one bit wider, so overflow shows up as a
  // disagreement between the top two bits. On overflow the result is clamped to the
  // signed limit that matches the true sign.
  function automatic fixed_term_t sat_add(input fixed_term_t a, input fixed_term_t b,
                                          output logic ovf);
    logic signed [DEF_W:0] wide;
    wide = {a[DEF_W-1], a} + {b[DEF_W-1], b};
    ovf  = wide[DEF_W] ^ wide[DEF_W-1];
    if (!ovf) return wide[DEF_W-1:0];
    if (wide[DEF_W]) return {1'b1, {(DEF_W-1){1'b0}}};
    return {1'b0, {(DEF_W-1){1'b1}}};
  endfunction

endpackage

// File: rtl/element_delay_accumulator_sat_adder.sv
// Combinational W-bit signed saturating adder with an overflow flag.
module sat_adder
  import delay_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum,
  output logic                ovf
);

  localparam logic signed [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

  // Returns {overflow, clamped sum}. The guard bit catches any wrap of the W-bit result.
  function automatic logic [W:0] sat_add_w(input logic signed [W-1:0] x,
                                           input logic signed [W-1:0] y);
    logic signed [W:0] wide;
    logic              o;
    wide = {x[W-1], x} + {y[W-1], y};
    o    = wide[W] ^ wide[W-1];
    if (!o) return {1'b0, wide[W-1:0]};
    return wide[W] ? {1'b1, MIN_V} : {1'b1, MAX_V};
  endfunction

  // Saturating sum and overflow indication
  always_comb begin
    {ovf, sum} = sat_add_w(a, b);
  end

endmodule

// File: rtl/element_delay_accumulator.sv
// Element delay accumulator. It seeds two fixed-point delays from r_0, then, for each
// array step, fetches one increment-term pair from the term calculator
// (initiate/ready/ack) and streams the accumulated delay pair downstream.
module element_delay_accumulator
  import delay_pkg::*;
#(
  parameter int DW_INTEGER  = DEF_DW_INTEGER,
  parameter int DW_FRACTION = DEF_DW_FRACTION,
  parameter int DW_INPUT    = 8,
  parameter int NUM_STEPS   = 32,
  parameter int IDX_W       = 5
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic [DW_INPUT-1:0]                         r_0,
  output logic                                        initiate,
  output logic                                        ack,
  input  logic                                        term_ready,
  input  logic signed [DW_INTEGER+DW_FRACTION:0]      term_pos_n,
  input  logic signed [DW_INTEGER+DW_FRACTION:0]      term_neg_n,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [IDX_W-1:0]                            out_index,
  output logic signed [DW_INTEGER+DW_FRACTION:0]      out_delay_pos,
  output logic signed [DW_INTEGER+DW_FRACTION:0]      out_delay_neg,
  output logic                                        busy,
  output logic                                        done,
  output logic                                        ovf
);

  localparam int W = DW_INTEGER + DW_FRACTION + 1;

  acc_state_e          state_q;
  acc_state_e          state_d;
  logic signed [W-1:0] acc_pos;
  logic signed [W-1:0] acc_neg;
  logic signed [W-1:0] sum_pos;
  logic signed [W-1:0] sum_neg;
  logic signed [W-1:0] seed;
  logic                ovf_pos;
  logic                ovf_neg;
  logic                ovf_q;
  logic [IDX_W-1:0]    index_q;
  logic                start_ok;
  logic                emit_fire;
  logic                last_step;

  // r_0 is an integer distance. Zero-extend it and place it above the fraction bits.
  assign seed      = W'({r_0, {DW_FRACTION{1'b0}}});
  assign start_ok  = (state_q == ST_IDLE) && start;
  assign emit_fire = (state_q == ST_EMIT) && out_ready;
  assign last_step = (index_q == IDX_W'(NUM_STEPS - 1));

  sat_adder #(.W(W)) u_sat_pos (
    .a   (acc_pos),
    .b   (term_pos_n),
    .sum (sum_pos),
    .ovf (ovf_pos)
  );

  sat_adder #(.W(W)) u_sat_neg (
    .a   (acc_neg),
    .b   (term_neg_n),
    .sum (sum_neg),
    .ovf (ovf_neg)
  );

  // State register; a reset abandons any scan line in progress
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state and handshake strobes. Initiate waits for term_ready to read low, so a
  // ready level left over from the previous step is never taken as a fresh answer.
  always_comb begin
    state_d   = state_q;
    initiate  = 1'b0;
    ack       = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (!term_ready) begin
          initiate = 1'b1;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (term_ready) state_d = ST_ACK;
      end
      ST_ACK: begin
        ack     = 1'b1;
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = last_step ? ST_DONE : ST_ISSUE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Accumulators, step index and sticky overflow. The terms are taken in the ACK cycle,
  // and the result is held through EMIT until the downstream accepts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_pos <= '0;
      acc_neg <= '0;
      index_q <= '0;
      ovf_q   <= 1'b0;
    end else if (start_ok) begin
      acc_pos <= seed;
      acc_neg <= seed;
      index_q <= '0;
      ovf_q   <= 1'b0;
    end else if (state_q == ST_ACK) begin
      acc_pos <= sum_pos;
      acc_neg <= sum_neg;
      if (ovf_pos || ovf_neg) ovf_q <= 1'b1;
    end else if (emit_fire && !last_step) begin
      index_q <= index_q + 1'b1;
    end
  end

  assign out_index     = index_q;
  assign out_delay_pos = acc_pos;
  assign out_delay_neg = acc_neg;
  assign busy          = (state_q != ST_IDLE);
  assign ovf           = ovf_q;

endmodule

// File: tb/tb_element_delay_accumulator.sv
// Bench for element_delay_accumulator. It has a stub term calculator, a downstream
// that can apply backpressure, and a reference model that builds the expected delay
// stream for each scan line.
module tb_element_delay_accumulator;

  localparam int DW_INTEGER  = 18;
  localparam int DW_FRACTION = 6;
  localparam int DW_INPUT    = 8;
  localparam int NUM_STEPS   = 32;
  localparam int IDX_W       = 5;
  localparam int W           = DW_INTEGER + DW_FRACTION + 1;
  localparam longint MAXV    = (64'sd1 <<< (W - 1)) - 1;
  localparam longint MINV    = -(64'sd1 <<< (W - 1));

  typedef struct {
    int     idx;
    longint pos;
    longint neg;
    bit     ovf;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [DW_INPUT-1:0] r_0;
  logic                initiate;
  logic                ack;
  logic                term_ready;
  logic signed [W-1:0] term_pos_n;
  logic signed [W-1:0] term_neg_n;
  logic                out_valid;
  logic                out_ready;
  logic [IDX_W-1:0]    out_index;
  logic signed [W-1:0] out_delay_pos;
  logic signed [W-1:0] out_delay_neg;
  logic                busy;
  logic                done;
  logic                ovf;

  int   vec  = 0;
  int   miss = 0;
  exp_t q[$];
  bit   exp_ovf;

  int rdy_delay = 1;
  int drop_delay = 1;
  int bp_idx = -1;
  int run_id = 0;

  int ini_cnt = 0;
  int ack_cnt = 0;
  int done_cnt = 0;
  int out_cnt = 0;

  element_delay_accumulator #(
    .DW_INTEGER(DW_INTEGER), .DW_FRACTION(DW_FRACTION), .DW_INPUT(DW_INPUT),
    .NUM_STEPS(NUM_STEPS), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .r_0(r_0),
    .initiate(initiate), .ack(ack), .term_ready(term_ready),
    .term_pos_n(term_pos_n), .term_neg_n(term_neg_n),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .out_delay_pos(out_delay_pos), .out_delay_neg(out_delay_neg),
    .busy(busy), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint req);
    vec++;
    if (act != req) begin
      miss++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference model: the delays start at r_0 scaled by 2^DW_FRACTION. Each step adds the
  // term, then clamps to the signed W-bit range. The overflow flag stays set once any
  // clamp has happened.
  task automatic build_expect(input int r0, input longint tp, input longint tn);
    longint p, n;
    bit     ov;
    exp_t   e;
    q.delete();
    p  = longint'(r0) * (64'sd1 <<< DW_FRACTION);
    n  = p;
    ov = 1'b0;
    for (int s = 0; s < NUM_STEPS; s++) begin
      p = p + tp;
      n = n + tn;
      if (p > MAXV) begin p = MAXV; ov = 1'b1; end
      if (p < MINV) begin p = MINV; ov = 1'b1; end
      if (n > MAXV) begin n = MAXV; ov = 1'b1; end
      if (n < MINV) begin n = MINV; ov = 1'b1; end
      e.idx = s; e.pos = p; e.neg = n; e.ovf = ov;
      q.push_back(e);
    end
    exp_ovf = ov;
  endtask

  // Stub term calculator: raises ready rdy_delay cycles after initiate and drops it
  // drop_delay cycles after ack
  initial begin
    int   rise_cnt;
    int   drop_cnt;
    logic ini_s, ack_s, rst_s;
    term_ready = 1'b0;
    rise_cnt   = 0;
    drop_cnt   = 0;
    forever begin
      @(negedge clk);
      ini_s = initiate; ack_s = ack; rst_s = rst;
      @(posedge clk); #1;
      if (rst_s) begin
        rise_cnt = 0; drop_cnt = 0; term_ready = 1'b0;
      end else begin
        if (rise_cnt > 0) begin rise_cnt--; if (rise_cnt == 0) term_ready = 1'b1; end
        if (drop_cnt > 0) begin drop_cnt--; if (drop_cnt == 0) term_ready = 1'b0; end
        if (ini_s) begin
          if (rdy_delay <= 1) term_ready = 1'b1; else rise_cnt = rdy_delay - 1;
        end
        if (ack_s) begin
          if (drop_delay <= 1) term_ready = 1'b0; else drop_cnt = drop_delay - 1;
        end
      end
    end
  end

  // Downstream: holds out_ready low for 5 cycles when it first sees index bp_idx in a run
  initial begin
    int bp_run;
    bp_run    = -1;
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bp_idx >= 0 && bp_run != run_id && out_valid && int'(out_index) == bp_idx) begin
        bp_run    = run_id;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    end
  end

  // Per-cycle checker against the model queue and the handshake rules
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (initiate) ini_cnt++;
        if (ack) ack_cnt++;
        if (initiate || ack) chk("initiate_ack_exclusive", longint'(initiate && ack), 0);
        if (initiate) chk("initiate_while_ready", longint'(term_ready), 0);
        if (done) begin
          done_cnt++;
          chk("done_before_last_output", longint'(q.size()), 0);
        end
        if (out_valid) begin
          chk("initiate_during_emit", longint'(initiate), 0);
          if (q.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            chk("out_index", longint'(out_index), longint'(q[0].idx));
            chk("out_delay_pos", longint'(out_delay_pos), q[0].pos);
            chk("out_delay_neg", longint'(out_delay_neg), q[0].neg);
            chk("ovf_at_step", longint'(ovf), longint'(q[0].ovf));
            if (out_ready) begin
              void'(q.pop_front());
              out_cnt++;
            end
          end
        end
      end
    end
  end

  // Runs one scan line; inj >= 0 fires a stray start (r_0 = 99) that many cycles in
  task automatic run_line(input int r0, input longint tp, input longint tn,
                          input int rdy, input int drp, input int bp, input int inj);
    int i0, a0, d0, o0;
    build_expect(r0, tp, tn);
    term_pos_n = W'(tp);
    term_neg_n = W'(tn);
    rdy_delay  = rdy;
    drop_delay = drp;
    bp_idx     = bp;
    run_id++;
    i0 = ini_cnt; a0 = ack_cnt; d0 = done_cnt; o0 = out_cnt;
    @(posedge clk); #1;
    r_0   = DW_INPUT'(r0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", longint'(busy), 1);
    chk("ovf_cleared_by_start", longint'(ovf), 0);
    for (int c = 0; c < 4000 && done_cnt == d0; c++) begin
      @(posedge clk); #1;
      start = (c == inj);
      if (c == inj) r_0 = 8'd99;
    end
    start = 1'b0;
    chk("done_seen_in_budget", longint'(done_cnt != d0), 1);
    @(negedge clk);
    chk("outputs_per_line", longint'(out_cnt - o0), NUM_STEPS);
    chk("done_pulses", longint'(done_cnt - d0), 1);
    chk("initiates_per_line", longint'(ini_cnt - i0), NUM_STEPS);
    chk("acks_per_line", longint'(ack_cnt - a0), NUM_STEPS);
    chk("busy_after_done", longint'(busy), 0);
    chk("ovf_final", longint'(ovf), longint'(exp_ovf));
    bp_idx = -1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int i0, o0, d0;
    bit reached;
    rst        = 1'b1;
    start      = 1'b0;
    r_0        = '0;
    term_pos_n = '0;
    term_neg_n = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", longint'(busy), 0);
    chk("reset_initiate", longint'(initiate), 0);
    chk("reset_ack", longint'(ack), 0);
    chk("reset_out_valid", longint'(out_valid), 0);
    chk("reset_index", longint'(out_index), 0);
    chk("reset_delay_pos", longint'(out_delay_pos), 0);
    chk("reset_delay_neg", longint'(out_delay_neg), 0);
    chk("reset_done", longint'(done), 0);
    chk("reset_ovf", longint'(ovf), 0);

    // Normal run, with the model pinned to hand-computed values at the last step
    build_expect(10, 64, -64);
    chk("model_idx31_pos", q[31].pos, 2688);
    chk("model_idx31_neg", q[31].neg, -1408);
    run_line(10, 64, -64, 1, 1, -1, -1);

    // Slow calculator: ready 7 cycles after initiate
    run_line(10, 64, -64, 7, 1, -1, -1);

    // Backpressure at index 3, with ready held longer so ISSUE must wait it out
    run_line(20, 100, -37, 2, 3, 3, -1);

    // Saturation on the positive side
    build_expect(255, 64'sd1 <<< 23, -5);
    chk("model_sat_step0", q[0].pos, 8404928);
    chk("model_sat_step1", q[1].pos, 16777215);
    chk("model_sat_step31", q[31].pos, 16777215);
    run_line(255, 64'sd1 <<< 23, -5, 1, 1, -1, -1);
    chk("ovf_sticky_after_sat", longint'(ovf), 1);

    // Stray start while busy; this start also clears the previous overflow
    run_line(7, -3, 129, 1, 1, -1, 40);

    // Reset while in WAIT at index 5, with start asserted in the same cycle
    build_expect(10, 64, -64);
    term_pos_n = W'(64);
    term_neg_n = W'(-64);
    rdy_delay  = 20;
    drop_delay = 1;
    run_id++;
    i0 = ini_cnt; o0 = out_cnt; d0 = done_cnt;
    @(posedge clk); #1 r_0 = 8'd10; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    reached = 1'b0;
    for (int c = 0; c < 3000 && !reached; c++) begin
      @(posedge clk); #1;
      reached = (out_cnt - o0 >= 5) && (ini_cnt - i0 >= 6);
    end
    chk("reached_wait_idx5", longint'(reached), 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1; start = 1'b1; r_0 = 8'd50;
    @(posedge clk);
    #1 rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_initiate", longint'(initiate), 0);
    chk("midrst_ack", longint'(ack), 0);
    chk("midrst_out_valid", longint'(out_valid), 0);
    chk("midrst_index", longint'(out_index), 0);
    chk("midrst_delay_pos", longint'(out_delay_pos), 0);
    chk("midrst_delay_neg", longint'(out_delay_neg), 0);
    chk("midrst_ovf", longint'(ovf), 0);
    q.delete();
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("midrst_no_done", longint'(done_cnt - d0), 0);
    chk("midrst_stays_idle", longint'(busy), 0);

    // Fresh line after the reset starts from 3 << 6 = 192
    build_expect(3, 64, -64);
    chk("model_r3_idx0_pos", q[0].pos, 256);
    chk("model_r3_idx0_neg", q[0].neg, 128);
    run_line(3, 64, -64, 1, 1, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/element_delay_accumulator.md
Name: element_delay_accumulator

Overview:
- Initiator/consumer side of the NextElementIncrementTermCalculator initiate/ready/ack handshake.
- Per scan line, seeds two fixed-point accumulators with r_0, then for each array step:
  - requests one increment-term pair;
  - acknowledges it;
  - adds the terms to the positive-side and negative-side delays;
  - streams the resulting element delays to the downstream delay table over a valid/ready channel.

Parameters:
- DW_INTEGER, 18, integer bits of fixed-point delay/term.
- DW_FRACTION, 6, fraction bits of fixed-point delay/term.
- DW_INPUT, 8, width of r_0 (integer distance, no fraction).
- NUM_STEPS, 32, number of term requests per scan line (≥1).
- IDX_W, 5, width of out_index; must satisfy 2^IDX_W ≥ NUM_STEPS.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; begin a scan line. Ignored unless IDLE.
- r_0  in  DW_INPUT  initial distance; latched on accepted start.
- initiate  out  1  one-cycle request pulse to the term calculator.
- ack  out  1  one-cycle acknowledge pulse to the term calculator.
- term_ready  in  1  calculator ready level (high until ack).
- term_pos_n  in  DW_INTEGER+DW_FRACTION+1  signed two's-complement increment, positive side.
- term_neg_n  in  DW_INTEGER+DW_FRACTION+1  signed two's-complement increment, negative side.
- out_valid  out  1  delay pair valid.
- out_ready  in  1  downstream accepts.
- out_index  out  IDX_W  step index 0..NUM_STEPS-1.
- out_delay_pos  out  DW_INTEGER+DW_FRACTION+1  signed accumulated delay, positive side.
- out_delay_neg  out  DW_INTEGER+DW_FRACTION+1  signed accumulated delay, negative side.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last output handshake.
- ovf  out  1  sticky saturation flag; cleared on accepted start or rst.

Behaviour:
- Width rule: W = DW_INTEGER+DW_FRACTION+1.
- Reset: all outputs 0; accumulators 0; index 0; state IDLE.
- rst mid-operation: abandon immediately; initiate and ack are 0 in the following cycle; no done pulse.
- States: IDLE, ISSUE, WAIT, ACK, EMIT, DONE.
- IDLE:
  - On start, latch acc_pos = acc_neg = zero-extended r_0 << DW_FRACTION; index = 0; clear ovf.
  - Go to ISSUE.
- ISSUE:
  - Hold while term_ready = 1, so a stale ready from the previous step is never consumed.
  - When term_ready = 0, assert initiate for exactly this cycle, then go to WAIT.
- WAIT: hold until term_ready = 1, then go to ACK. No timeout.
- ACK (exactly one cycle):
  - Assert ack.
  - Capture acc_pos = sat(acc_pos + term_pos_n) and acc_neg = sat(acc_neg + term_neg_n), using terms sampled in this cycle.
  - Go to EMIT.
- Saturating add:
  - Compute in W+1 bits.
  - On overflow, clamp to +(2^(W-1))-1 or -(2^(W-1)) and set ovf.
- EMIT:
  - out_valid = 1; out_delay_* = accumulators; out_index = index.
  - Outputs stay stable until out_valid && out_ready.
  - On that handshake: if index = NUM_STEPS-1, go to DONE; else index+1 and go to ISSUE.
  - out_ready held high gives one cycle in EMIT.
- DONE: done = 1 for one cycle, then IDLE.
- Minimum per-step latency: ISSUE(1) + WAIT(≥1) + ACK(1) + EMIT(1).
- initiate and ack are never asserted in the same cycle, and never outside ISSUE/ACK.
- start while busy: ignored, with no effect on r_0 or state.
- start in the same cycle as rst: rst wins.
- term_ready dropping during WAIT before it is sampled high: keep waiting.

Decomposition:
- Shared package delay_pkg:
  - DW_INTEGER / DW_FRACTION defaults;
  - typedef fixed_term_t (signed W bits);
  - state enum acc_state_e;
  - function sat_add(a, b, ovf).
- One natural sub-module, sat_adder: a combinational W-bit signed saturating adder with overflow output, instantiated twice (pos and neg).

Test Plan:
- Normal run:
  - Stimulus: r_0 = 10; stub calculator returns pos = +64, neg = -64 every step; out_ready = 1.
  - Required: 32 outputs; step n gives pos = 640+64(n+1) and neg = 640-64(n+1), so index 31 gives pos = 2688, neg = -1408.
  - Required: done pulses once; ovf = 0.
- Handshake timing:
  - Stimulus: stub raises term_ready 7 cycles after initiate and drops it 1 cycle after ack.
  - Required: exactly one initiate and one ack per step; initiate never issued while term_ready = 1.
- Backpressure:
  - Stimulus: out_ready low for 5 cycles at index 3.
  - Required: out_valid stays high with index 3 and delays unchanged; no initiate until the handshake completes.
- Saturation:
  - Stimulus: r_0 = 255; pos = +2^23 every step.
  - Required: acc_pos clamps at 2^24-1 = 16777215 by step 1 and holds there; ovf set and sticky.
  - Required: the next start clears ovf.
- Reset mid-run:
  - Stimulus: rst asserted while in WAIT at index 5.
  - Required: next cycle all outputs 0 and state IDLE; no done pulse.
  - Required: a new start with r_0 = 3 produces index 0 from base 192.
- Start while busy:
  - Stimulus: a second start pulse with r_0 = 99 mid-run.
  - Required: ignored; the original sequence completes unchanged.
